// File: rtl/alu_op_driver_pkg.sv
// ---------------------------------------------------------------------------
// alu_op_driver_pkg
// Shared definitions for the ALU operation driver:
//   - ALU control code constants (the six legal operations)
//   - FSM state encoding
//   - legality check for a 4-bit ALU control code
// ---------------------------------------------------------------------------
package alu_op_driver_pkg;

   // ALU control codes understood by the downstream ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Width of the settle down-counter; covers SETTLE_CYCLES up to 15
   localparam int SETTLE_W = 4;

   // Driver FSM states (fixed encodings for legacy compatibility)
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Returns 1 for one of the six supported ALU control codes
   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         ALU_AND,
         ALU_OR,
         ALU_ADD,
         ALU_SUB,
         ALU_SLT,
         ALU_NOR: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_op_driver_counter.sv
// ---------------------------------------------------------------------------
// alu_op_counter
// CNT_W-bit statistics counter with increment enable. Saturates at all-ones
// instead of wrapping so long runs never report a misleadingly small count.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset, clears the count
//   inc_i    in   increment by one on this edge (ignored when saturated)
//   count_o  out  current count
// ---------------------------------------------------------------------------
module alu_op_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic at_max;

   assign at_max = &count_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (inc_i && !at_max) begin
         count_o <= count_o + 1'b1;
      end
   end

endmodule

// File: rtl/alu_op_driver.sv
// ---------------------------------------------------------------------------
// alu_op_driver
// Accepts one ALU operation request at a time, drives it onto an external
// combinational ALU, lets the ALU inputs settle for SETTLE_CYCLES cycles,
// registers the ALU result/flags and presents them on a valid/ready
// response port. Illegal control codes are answered immediately with an
// illegal flag and never reach the ALU. Two saturating counters track
// completed legal ops and completed ops that reported overflow.
//
// Parameters
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//   CNT_W          width of the statistics counters
//
// Ports
//   clk_i                 in   clock, rising edge
//   rst_i                 in   asynchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only when idle)
//   req_op_i/a_i/b_i      request payload: ALU code, operands
//   alu_src1_o/src2_o     ALU operand drive
//   alu_ctrl_o            ALU control code drive
//   alu_rst_n_o           ALU reset, active-low copy of rst_i
//   alu_result_i, alu_zero_i, alu_cout_i, alu_overflow_i   ALU outputs
//   rsp_valid_o/ready_i   response handshake
//   rsp_result_o, rsp_zero_o, rsp_cout_o, rsp_overflow_o, rsp_illegal_o
//                         registered response payload
//   op_count_o            completed legal ops (saturating)
//   ovf_count_o           completed ops with overflow (saturating)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready for a request; latch it on handshake
// ST_SETTLE  | ALU driven from the latched request, settle counter running
// ST_CAPTURE | ALU result and flags registered into the response registers
// ST_RESP    | response valid, payload held until rsp_ready_i
// ---------------------------------------------------------------------------
module alu_op_driver
   import alu_op_driver_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [3:0]       req_op_i,
   input  logic [31:0]      req_a_i,
   input  logic [31:0]      req_b_i,

   output logic [31:0]      alu_src1_o,
   output logic [31:0]      alu_src2_o,
   output logic [3:0]       alu_ctrl_o,
   output logic             alu_rst_n_o,
   input  logic [31:0]      alu_result_i,
   input  logic             alu_zero_i,
   input  logic             alu_cout_i,
   input  logic             alu_overflow_i,

   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_cout_o,
   output logic             rsp_overflow_o,
   output logic             rsp_illegal_o,

   output logic [CNT_W-1:0] op_count_o,
   output logic [CNT_W-1:0] ovf_count_o
);

   // The settle counter is a down-counter loaded with SETTLE_CYCLES-1 at
   // accept; SETTLE exits on the cycle it reads zero, giving exactly
   // SETTLE_CYCLES cycles of settle time.
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   state_t              state;
   logic [SETTLE_W-1:0] settle_cnt;

   logic accept;
   logic req_legal;
   logic rsp_xfer;
   logic settle_done;
   logic op_inc;
   logic ovf_inc;

   assign req_ready_o = (state == ST_IDLE);
   assign rsp_valid_o = (state == ST_RESP);
   assign accept      = req_valid_i & req_ready_o;
   assign req_legal   = is_legal_op(req_op_i);
   assign rsp_xfer    = rsp_valid_o & rsp_ready_i;
   assign settle_done = (settle_cnt == '0);

   // Pure inversion so the ALU is held in reset for exactly as long as we are
   assign alu_rst_n_o = ~rst_i;

   // -----------------------------------------------------------------------
   // FSM and settle timer
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (req_legal) begin
                     state      <= ST_SETTLE;
                     settle_cnt <= SETTLE_LOAD;
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_done) begin
                  state <= ST_CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Request latch / ALU drive. The drive registers double as the request
   // latch: they only load on a legal accept, so an illegal request leaves
   // the ALU inputs untouched and they keep their last issued values.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_src1_o <= '0;
         alu_src2_o <= '0;
         alu_ctrl_o <= ALU_AND;
      end else if (accept && req_legal) begin
         alu_src1_o <= req_a_i;
         alu_src2_o <= req_b_i;
         alu_ctrl_o <= req_op_i;
      end
   end

   // -----------------------------------------------------------------------
   // Response registers. Loaded either from the ALU in CAPTURE or with the
   // fixed illegal-op response at accept; held otherwise, so the payload is
   // stable for the whole RESP stall and there is no combinational path
   // from the ALU outputs to the response port.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_result_o   <= '0;
         rsp_zero_o     <= 1'b0;
         rsp_cout_o     <= 1'b0;
         rsp_overflow_o <= 1'b0;
         rsp_illegal_o  <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         rsp_result_o   <= alu_result_i;
         rsp_zero_o     <= alu_zero_i;
         rsp_cout_o     <= alu_cout_i;
         rsp_overflow_o <= alu_overflow_i;
         rsp_illegal_o  <= 1'b0;
      end else if (accept && !req_legal) begin
         rsp_result_o   <= '0;
         rsp_zero_o     <= 1'b0;
         rsp_cout_o     <= 1'b0;
         rsp_overflow_o <= 1'b0;
         rsp_illegal_o  <= 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Statistics: counted at the response transfer edge, legal ops only.
   // rsp_overflow_o is always 0 for illegal ops, but gating on op_inc keeps
   // the intent explicit.
   // -----------------------------------------------------------------------
   assign op_inc  = rsp_xfer & ~rsp_illegal_o;
   assign ovf_inc = op_inc & rsp_overflow_o;

   alu_op_counter #(
      .CNT_W   (CNT_W)
   ) u_op_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (op_inc),
      .count_o (op_count_o)
   );

   alu_op_counter #(
      .CNT_W   (CNT_W)
   ) u_ovf_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (ovf_inc),
      .count_o (ovf_count_o)
   );

endmodule

// File: doc/alu_op_driver.md
ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, cycles the ALU inputs are held before the result is captured (legal range 1..15).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1, req_ready_o  out  1: operation request handshake.
REQ-006 req_op_i  in  4 (ALU control code), req_a_i  in  32, req_b_i  in  32: request payload.
REQ-007 alu_src1_o  out  32, alu_src2_o  out  32, alu_ctrl_o  out  4, alu_rst_n_o  out  1: ALU drive.
REQ-008 alu_result_i  in  32, alu_zero_i, alu_cout_i, alu_overflow_i  in  1 each: ALU outputs.
REQ-009 rsp_valid_o  out  1, rsp_ready_i  in  1: response handshake.
REQ-010 rsp_result_o  out  32, rsp_zero_o, rsp_cout_o, rsp_overflow_o, rsp_illegal_o  out  1 each: response payload.
REQ-011 op_count_o  out  CNT_W (completed legal ops), ovf_count_o  out  CNT_W (completed ops with overflow=1).

Function
REQ-012 Legal ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all others illegal.
REQ-013 FSM states IDLE, SETTLE, CAPTURE, RESP; req_ready_o = 1 only in IDLE.
REQ-014 IDLE: on req_valid_i & req_ready_o, latch op/a/b; legal op -> SETTLE, illegal op -> RESP.
REQ-015 SETTLE: alu_src1_o/alu_src2_o/alu_ctrl_o driven from latched request; settle counter counts SETTLE_CYCLES cycles, then -> CAPTURE.
REQ-016 CAPTURE: alu_result_i and three flags registered into response registers in one cycle; -> RESP.
REQ-017 Legal-op latency: rsp_valid_o asserts exactly SETTLE_CYCLES+2 cycles after the accepting edge.
REQ-018 Illegal op: ALU drive outputs unchanged, rsp_result_o=0, all flags 0, rsp_illegal_o=1, rsp_valid_o one cycle after accept.
REQ-019 RESP: rsp_valid_o=1, payload held stable until rsp_valid_o & rsp_ready_i; that edge -> IDLE.
REQ-020 rsp_ready_i high on first RESP cycle completes the transfer that cycle; no bubble-free back-to-back acceptance (new request earliest the cycle after return to IDLE).
REQ-021 ALU drive outputs hold last issued values outside SETTLE/CAPTURE.
REQ-022 rsp_zero_o is the captured ALU flag, not recomputed locally.
REQ-023 op_count_o increments by 1 at each legal-op response transfer; ovf_count_o increments at the same edge when rsp_overflow_o=1; both saturate at all-ones.
REQ-024 Illegal ops change neither counter.
REQ-025 alu_rst_n_o = ~rst_i combinationally.

Reset
REQ-026 rst_i asserted: FSM -> IDLE immediately, req_ready_o=1 after release, rsp_valid_o=0.
REQ-027 Reset values: alu_src1_o=0, alu_src2_o=0, alu_ctrl_o=0000, response payload 0, rsp_illegal_o=0, counters 0, settle counter 0.
REQ-028 Reset mid-operation aborts the op with no response and no counter update.

Structure
REQ-029 Shared package holds ALU control code constants (six codes), FSM state enum, and a legality-check function.
REQ-030 One sub-module, alu_op_counter: CNT_W saturating counter with increment enable, instantiated twice.
REQ-031 Request latch and response registers are flops; no combinational path from alu_*_i to rsp_*_o.

Verification
REQ-032 ADD a=0x7FFFFFFF b=1, ALU model returns 0x80000000 ovf=1 -> rsp_valid at accept+3 (SETTLE_CYCLES=1), result 0x80000000, overflow=1, ovf_count 1.
REQ-033 Op 1111 a=5 b=3 -> rsp_valid at accept+1, illegal=1, result 0, alu_ctrl_o still 0000, counters unchanged.
REQ-034 SUB a=9 b=9 with rsp_ready_i low 5 cycles -> payload (result 0, zero=1) stable all 5 cycles, req_ready_o low until transfer.
REQ-035 rst_i pulsed during SETTLE of AND op -> no response, all outputs at reset values, next OR 0xF0/0x0F returns 0xFF.
REQ-036 CNT_W=2, five legal ops -> op_count_o sequence 1,2,3,3,3.
REQ-037 SETTLE_CYCLES=4, SLT a=-1 b=1 -> alu_ctrl_o=0111 held 4 cycles, response result 1 at accept+6.
